// File: rtl/as_pack.sv
// rtl/as_pack.sv - shared GPIO widths and sequence-checker types
package as_pack;

  // GPIO write port geometry shared with the core and as_top_mem
  localparam int nr_gpios        = 8;
  localparam int gpio_addr_width = 8;

  // Checker verdict state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } seq_chk_state_t;

  // One expected GPIO write
  typedef struct packed {
    logic [gpio_addr_width-1:0] addr;
    logic [nr_gpios-1:0]        data;
  } exp_entry_t;

endpackage

// File: rtl/as_gpio_exp_ram.sv
// rtl/as_gpio_exp_ram.sv - expected-write table, sync write / async read
module as_gpio_exp_ram
  import as_pack::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  exp_entry_t       wentry_i,
  input  logic [IDX_W-1:0] ridx_i,
  output exp_entry_t       rentry_o
);

  // No reset: contents are only meaningful after the table is loaded
  exp_entry_t r_mem [DEPTH];

  // Table write; indices beyond the table are dropped
  always_ff @(posedge clk_i) begin
    if (we_i && (int'(widx_i) < DEPTH)) begin
      r_mem[widx_i] <= wentry_i;
    end
  end

  assign rentry_o = r_mem[ridx_i];

endmodule

// File: rtl/as_gpio_seq_checker.sv
// rtl/as_gpio_seq_checker.sv - in-order GPIO write sequence checker with verdict
module as_gpio_seq_checker
  import as_pack::*;
#(
  parameter int SEQ_DEPTH = 16,
  parameter int WATCH_LO  = 0,
  parameter int WATCH_HI  = 7,
  parameter int TIMEOUT   = 4096,
  localparam int IDX_W    = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1,
  localparam int CNT_W    = $clog2(SEQ_DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cs_i,
  input  logic [gpio_addr_width-1:0] gpioAddr_i,
  input  logic [nr_gpios-1:0]        gpio_i,
  input  logic                       exp_we_i,
  input  logic [IDX_W-1:0]           exp_idx_i,
  input  logic [gpio_addr_width-1:0] exp_addr_i,
  input  logic [nr_gpios-1:0]        exp_data_i,
  input  logic [CNT_W-1:0]           exp_len_i,
  input  logic                       start_i,
  input  logic                       clear_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       fail_o,
  output logic                       timeout_o,
  output logic [CNT_W-1:0]           match_cnt_o,
  output logic [15:0]                ign_cnt_o,
  output logic [CNT_W-1:0]           fail_idx_o,
  output logic [gpio_addr_width-1:0] fail_addr_o,
  output logic [nr_gpios-1:0]        fail_data_o
);

  // Timer only has to hold 0..TIMEOUT-1; it fails on the edge that would reach TIMEOUT
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  seq_chk_state_t             r_state;
  seq_chk_state_t             w_state_nxt;
  logic [CNT_W-1:0]           r_len;
  logic [CNT_W-1:0]           r_ptr;
  logic [TMR_W-1:0]           r_timer;
  logic [15:0]                r_ign;
  logic                       r_timeout;
  logic [CNT_W-1:0]           r_fail_idx;
  logic [gpio_addr_width-1:0] r_fail_addr;
  logic [nr_gpios-1:0]        r_fail_data;

  exp_entry_t                 w_exp;
  exp_entry_t                 w_wentry;
  logic [CNT_W-1:0]           w_len_clamp;
  logic                       w_in_window;
  logic                       w_hit;
  logic                       w_timer_last;
  logic                       w_start;
  logic                       w_match;
  logic                       w_ignore;
  logic                       w_mismatch;
  logic                       w_expire;
  logic                       w_tick;

  assign w_wentry = '{addr: exp_addr_i, data: exp_data_i};

  // Table is frozen once armed so a running check cannot be disturbed
  as_gpio_exp_ram #(
    .DEPTH (SEQ_DEPTH),
    .IDX_W (IDX_W)
  ) u_exp_ram (
    .clk_i    (clk_i),
    .we_i     (exp_we_i && (r_state == ST_IDLE)),
    .widx_i   (exp_idx_i),
    .wentry_i (w_wentry),
    .ridx_i   (r_ptr[IDX_W-1:0]),
    .rentry_o (w_exp)
  );

  assign w_len_clamp  = (exp_len_i > CNT_W'(SEQ_DEPTH)) ? CNT_W'(SEQ_DEPTH) : exp_len_i;
  // Signed int compare keeps a zero lower bound from becoming a constant-true check
  assign w_in_window  = (int'(gpioAddr_i) >= WATCH_LO) && (int'(gpioAddr_i) <= WATCH_HI);
  assign w_hit        = (gpioAddr_i == w_exp.addr) && (gpio_i == w_exp.data);
  assign w_timer_last = (TIMEOUT != 0) && (r_timer == TMR_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes; clear beats a write, a write beats the timer
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_match     = 1'b0;
    w_ignore    = 1'b0;
    w_mismatch  = 1'b0;
    w_expire    = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!clear_i && start_i) begin
          w_start     = 1'b1;
          w_state_nxt = (w_len_clamp == '0) ? ST_PASS : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (clear_i) begin
          w_state_nxt = ST_IDLE;
        end else if (cs_i && w_in_window && w_hit) begin
          w_match = 1'b1;
          if ((r_ptr + CNT_W'(1)) == r_len) begin
            w_state_nxt = ST_PASS;
          end
        end else if (cs_i && w_in_window) begin
          w_mismatch  = 1'b1;
          w_state_nxt = ST_FAIL;
        end else begin
          // Out-of-window writes are counted but do not hold off the timeout
          w_ignore = cs_i;
          w_tick   = 1'b1;
          if (w_timer_last) begin
            w_expire    = 1'b1;
            w_state_nxt = ST_FAIL;
          end
        end
      end
      ST_PASS, ST_FAIL: begin
        if (clear_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters, timer and failure capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len       <= '0;
      r_ptr       <= '0;
      r_timer     <= '0;
      r_ign       <= '0;
      r_timeout   <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      if (w_start) begin
        r_len       <= w_len_clamp;
        r_ptr       <= '0;
        r_timer     <= '0;
        r_ign       <= '0;
        r_timeout   <= 1'b0;
        r_fail_idx  <= '0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end
      if (w_match) begin
        r_ptr   <= r_ptr + CNT_W'(1);
        r_timer <= '0;
      end else if (w_tick) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_ignore && (r_ign != 16'hFFFF)) begin
        r_ign <= r_ign + 16'd1;
      end
      if (w_mismatch) begin
        r_fail_idx  <= r_ptr;
        r_fail_addr <= gpioAddr_i;
        r_fail_data <= gpio_i;
      end
      if (w_expire) begin
        r_timeout   <= 1'b1;
        r_fail_idx  <= r_ptr;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end
    end
  end

  assign busy_o      = (r_state == ST_ARMED);
  assign pass_o      = (r_state == ST_PASS);
  assign fail_o      = (r_state == ST_FAIL);
  assign done_o      = pass_o || fail_o;
  assign timeout_o   = r_timeout;
  assign match_cnt_o = r_ptr;
  assign ign_cnt_o   = r_ign;
  assign fail_idx_o  = r_fail_idx;
  assign fail_addr_o = r_fail_addr;
  assign fail_data_o = r_fail_data;

endmodule

// File: tb/tb_as_gpio_seq_checker.sv
// tb/tb_as_gpio_seq_checker.sv - self-checking bench for as_gpio_seq_checker
module tb_as_gpio_seq_checker;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_i, cs_i, exp_we_i, start_i, clear_i;
  logic [7:0] gpioAddr_i, gpio_i, exp_addr_i, exp_data_i;
  logic [3:0] exp_idx_i;
  logic [4:0] exp_len_i;
  logic       busy_o, done_o, pass_o, fail_o, timeout_o;
  logic [4:0] match_cnt_o, fail_idx_o;
  logic [15:0] ign_cnt_o;
  logic [7:0] fail_addr_o, fail_data_o;

  int total = 0;
  int bad   = 0;

  as_gpio_seq_checker #(
    .SEQ_DEPTH (16),
    .WATCH_LO  (0),
    .WATCH_HI  (7),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cs_i        (cs_i),
    .gpioAddr_i  (gpioAddr_i),
    .gpio_i      (gpio_i),
    .exp_we_i    (exp_we_i),
    .exp_idx_i   (exp_idx_i),
    .exp_addr_i  (exp_addr_i),
    .exp_data_i  (exp_data_i),
    .exp_len_i   (exp_len_i),
    .start_i     (start_i),
    .clear_i     (clear_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .match_cnt_o (match_cnt_o),
    .ign_cnt_o   (ign_cnt_o),
    .fail_idx_o  (fail_idx_o),
    .fail_addr_o (fail_addr_o),
    .fail_data_o (fail_data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        cs;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        e_busy;
    logic        e_pass;
    logic        e_fail;
    logic [4:0]  e_match;
    logic [15:0] e_ign;
  } vec_t;

  vec_t vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic load(input int idx, input logic [7:0] a, input logic [7:0] d);
    exp_we_i   = 1'b1;
    exp_idx_i  = 4'(idx);
    exp_addr_i = a;
    exp_data_i = d;
    tick();
    exp_we_i   = 1'b0;
  endtask

  task automatic arm(input int len);
    exp_len_i = 5'(len);
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cs_i       = 1'b1;
    gpioAddr_i = a;
    gpio_i     = d;
    tick();
    cs_i       = 1'b0;
  endtask

  task automatic clr();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  // Reference model state for random runs
  logic [7:0] m_addr [16];
  logic [7:0] m_data [16];

  initial begin
    int n;
    vt[0] = '{1'b1, 8'h04, 8'h01, 1'b1, 1'b0, 1'b0, 5'd1, 16'd0};
    vt[1] = '{1'b1, 8'h20, 8'h07, 1'b1, 1'b0, 1'b0, 5'd1, 16'd1};
    vt[2] = '{1'b1, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0, 5'd2, 16'd1};
    vt[3] = '{1'b1, 8'h04, 8'h03, 1'b0, 1'b1, 1'b0, 5'd3, 16'd1};
    vt[4] = '{1'b1, 8'h04, 8'h09, 1'b0, 1'b1, 1'b0, 5'd3, 16'd1};
    vt[5] = '{1'b1, 8'h20, 8'h07, 1'b0, 1'b1, 1'b0, 5'd3, 16'd1};

    rst_i = 1'b1; cs_i = 1'b0; exp_we_i = 1'b0; start_i = 1'b0; clear_i = 1'b0;
    gpioAddr_i = '0; gpio_i = '0; exp_addr_i = '0; exp_data_i = '0;
    exp_idx_i = '0; exp_len_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    chk("reset_outputs", {busy_o, done_o, pass_o, fail_o, timeout_o, match_cnt_o,
                          ign_cnt_o, fail_idx_o, fail_addr_o, fail_data_o}, 64'd0);

    // Single-entry pass
    load(0, 8'd4, 8'd29);
    arm(1);
    chk("start_busy", busy_o, 1);
    wr(8'd4, 8'd29);
    chk("t1_pass", pass_o, 1);
    chk("t1_match", match_cnt_o, 1);
    chk("t1_fail", fail_o, 0);
    clr();

    // Single-entry data mismatch
    arm(1);
    wr(8'd4, 8'h1C);
    chk("t2_fail", fail_o, 1);
    chk("t2_fidx", fail_idx_o, 0);
    chk("t2_faddr", fail_addr_o, 4);
    chk("t2_fdata", fail_data_o, 8'h1C);
    chk("t2_timeout", timeout_o, 0);
    clr();
    chk("t2_clear_done", done_o, 0);

    // Back-to-back with an interleaved out-of-window write, table driven
    load(0, 8'd4, 8'd1);
    load(1, 8'd5, 8'd2);
    load(2, 8'd4, 8'd3);
    arm(3);
    for (int i = 0; i < 6; i++) begin
      cs_i = vt[i].cs; gpioAddr_i = vt[i].addr; gpio_i = vt[i].data;
      tick();
      chk($sformatf("vec%0d", i), {busy_o, pass_o, fail_o, match_cnt_o, ign_cnt_o},
          {vt[i].e_busy, vt[i].e_pass, vt[i].e_fail, vt[i].e_match, vt[i].e_ign});
    end
    cs_i = 1'b0;
    clr();

    // Timeout exactly TO cycles after the last match
    load(0, 8'd1, 8'd10);
    load(1, 8'd2, 8'd20);
    arm(2);
    repeat (9) tick();
    wr(8'd1, 8'd10);
    chk("t4_match", match_cnt_o, 1);
    n = 0;
    while (!fail_o && n < 3 * TO) begin
      tick();
      n++;
    end
    chk("t4_latency", n, TO);
    chk("t4_timeout", timeout_o, 1);
    chk("t4_fidx", fail_idx_o, 1);
    chk("t4_faddr_fdata", {fail_addr_o, fail_data_o}, 0);
    clr();

    // Reset mid-ARMED discards everything
    load(0, 8'd3, 8'd5);
    load(1, 8'd3, 8'd6);
    arm(2);
    wr(8'd3, 8'd5);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_rst_all", {busy_o, done_o, pass_o, fail_o, timeout_o, match_cnt_o,
                       ign_cnt_o, fail_idx_o, fail_addr_o, fail_data_o}, 64'd0);

    // Table writes while ARMED must be ignored
    load(0, 8'd3, 8'd5);
    load(1, 8'd3, 8'd6);
    arm(2);
    load(1, 8'd3, 8'd9);
    wr(8'd3, 8'd5);
    wr(8'd3, 8'd6);
    chk("t5_frozen_pass", {pass_o, fail_o}, 2'b10);
    clr();

    // Zero length passes immediately, clamp of oversize length
    arm(0);
    chk("t6_len0_pass", {busy_o, pass_o}, 2'b01);
    clr();
    chk("t6_clear", {done_o, pass_o, busy_o}, 0);

    // Randomized runs against the reference model
    for (int run = 0; run < 40; run++) begin
      int req, len_eff, k, ign, since, f_idx, cyc, gap_at, gap_left, r;
      bit m_pass, m_fail, m_to, gap_done, c;
      logic [7:0] f_addr, f_data, a, d;
      req = $urandom_range(1, 20);
      len_eff = (req > 16) ? 16 : req;
      for (int i = 0; i < 16; i++) begin
        m_addr[i] = 8'($urandom_range(0, 7));
        m_data[i] = 8'($urandom);
        load(i, m_addr[i], m_data[i]);
      end
      arm(req);
      k = 0; ign = 0; since = 0; m_pass = 0; m_fail = 0; m_to = 0;
      f_idx = 0; f_addr = 0; f_data = 0; cyc = 0;
      gap_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len_eff - 1) : -1;
      gap_left = 0; gap_done = 0;
      while (!m_pass && !m_fail && cyc < 600) begin
        c = 0; a = 0; d = 0;
        if (gap_left > 0) begin
          gap_left--;
        end else if (k == gap_at && !gap_done) begin
          gap_done = 1;
          gap_left = $urandom_range(TO - 5, TO + 5);
        end else begin
          r = $urandom_range(0, 99);
          if (r < 50) begin
            c = 1; a = m_addr[k]; d = m_data[k];
          end else if (r < 70) begin
            c = 1; a = 8'($urandom_range(8, 255)); d = 8'($urandom);
          end else if (r < 71) begin
            c = 1; a = 8'($urandom_range(0, 7)); d = 8'($urandom);
          end
        end
        cs_i = c; gpioAddr_i = a; gpio_i = d;
        tick();
        cs_i = 1'b0;
        cyc++;
        if (c && a <= 8'd7) begin
          if (a == m_addr[k] && d == m_data[k]) begin
            k++;
            since = 0;
            if (k == len_eff) m_pass = 1;
          end else begin
            m_fail = 1; f_idx = k; f_addr = a; f_data = d;
          end
        end else begin
          if (c) ign++;
          since++;
          if (since == TO) begin
            m_fail = 1; m_to = 1; f_idx = k; f_addr = 0; f_data = 0;
          end
        end
        chk($sformatf("rnd%0d_c%0d", run, cyc),
            {pass_o, fail_o, busy_o, timeout_o, match_cnt_o, ign_cnt_o},
            {m_pass, m_fail, !(m_pass || m_fail), m_to, 5'(k), 16'(ign)});
      end
      if (m_fail) begin
        chk($sformatf("rnd%0d_fail_info", run), {fail_idx_o, fail_addr_o, fail_data_o},
            {5'(f_idx), f_addr, f_data});
      end
      clr();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/as_gpio_seq_checker.md
# as_gpio_seq_checker

Synthesizable self-check monitor on the core's GPIO write port (`cs`/`gpioAddr`/`gpio`), next to `as_top_mem`. It compares every GPIO write inside a watched address window against a loadable table of expected {address, data} pairs in order. It reports pass, fail (mismatch or timeout) and failure details as a registered verdict. Test programs can therefore be judged on FPGA or in any bench without per-test checking code.

## Interface
- `SEQ_DEPTH`, 16: expected-table entries, ≥1.
- `WATCH_LO`, 0: lowest watched GPIO address, inclusive.
- `WATCH_HI`, 7: highest watched GPIO address, inclusive.
- `TIMEOUT`, 4096: max clk cycles between start or last match and the next match; 0 disables the timeout.
- `clk_i` in 1: system clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `cs_i` in 1: GPIO write strobe from core.
- `gpioAddr_i` in `gpio_addr_width`: GPIO write address.
- `gpio_i` in `nr_gpios`: GPIO write data.
- `exp_we_i` in 1: expected-table write strobe.
- `exp_idx_i` in `$clog2(SEQ_DEPTH)`: table index.
- `exp_addr_i` in `gpio_addr_width`: expected address.
- `exp_data_i` in `nr_gpios`: expected data.
- `exp_len_i` in `$clog2(SEQ_DEPTH+1)`: number of valid entries; sampled at start.
- `start_i` in 1: arm checker.
- `clear_i` in 1: abandon/acknowledge, return to IDLE.
- `busy_o` out 1: ARMED.
- `done_o` out 1: PASS or FAIL.
- `pass_o` out 1: PASS.
- `fail_o` out 1: FAIL.
- `timeout_o` out 1: failure caused by timeout.
- `match_cnt_o` out `$clog2(SEQ_DEPTH+1)`: entries matched so far.
- `ign_cnt_o` out 16: out-of-window writes seen while ARMED; saturating.
- `fail_idx_o`, `fail_addr_o`, `fail_data_o`: entry index and offending write captured at failure.

## Operation
- States: IDLE, ARMED, PASS, FAIL.
- IDLE:
  - `exp_we_i` writes the table.
  - `start_i` latches `exp_len_i`, clears the counters and timer, and enters ARMED.
  - If the latched length is 0, enters PASS instead.
- ARMED, on `cs_i`=1:
  - Address outside [WATCH_LO, WATCH_HI]: increment `ign_cnt_o` only.
  - Address and data equal entry[ptr]: increment ptr and `match_cnt_o`, reload the timer. If ptr+1 equals the length, enter PASS.
  - Otherwise (in window, address or data differs): enter FAIL and capture ptr, address and data.
- ARMED without a match:
  - The timer increments each cycle.
  - Reaching TIMEOUT enters FAIL with `timeout_o`=1; `fail_idx_o`=ptr, `fail_addr_o`/`fail_data_o`=0.
- PASS/FAIL are sticky. `cs_i` is ignored there. Only `clear_i` or `rst_i` leaves them, returning to IDLE.
- Priority: `rst_i` > `clear_i` > `cs_i` event > timeout. A matching write in the same cycle the timer would expire counts as a match.
- Table writes are ignored outside IDLE.
- `start_i` is ignored outside IDLE.
- `exp_idx_i` ≥ SEQ_DEPTH is ignored.
- `exp_len_i` > SEQ_DEPTH is clamped to SEQ_DEPTH.
- Comparison is exact on the full `nr_gpios` data width; there is no mask.

## Timing
- Reset:
  - State IDLE.
  - All outputs 0, all counters 0.
  - Table contents undefined.
- Verdict latency: `pass_o`/`fail_o` rise one cycle after the deciding `cs_i` edge.
- Start latency: `busy_o` rises one cycle after `start_i`.
- `match_cnt_o` updates in the same cycle as the state change.
- Timeout fires exactly TIMEOUT cycles after `start_i` or the last match with no intervening match.
- Back-to-back `cs_i` on consecutive cycles is supported; one entry is consumed per cycle.
- A table write takes one cycle and is visible to a `start_i` in the following cycle.
- Reset mid-ARMED: IDLE on the next edge with the verdict discarded.

## Structure
- `as_pack` holds:
  - The state enum `seq_chk_state_t`.
  - The type `exp_entry_t` ({addr, data}).
  - Reuse of existing `nr_gpios` and `gpio_addr_width`.
- Sub-module `as_gpio_exp_ram`:
  - SEQ_DEPTH × `exp_entry_t`.
  - Synchronous write, asynchronous read on ptr.
  - Keeping it separate lets it map to distributed RAM.
- All other logic (FSM, timer, counters, capture registers) stays in one module.

## Test plan
- Load {4, 29}, len 1, start; write addr 4 data 29 → `pass_o`=1 next cycle, `match_cnt_o`=1, `fail_o`=0.
- Same load; write addr 4 data 0x1C → `fail_o`=1, `fail_idx_o`=0, `fail_addr_o`=4, `fail_data_o`=0x1C, `timeout_o`=0.
- Load {4,1},{5,2},{4,3}, len 3; back-to-back writes matching, with addr 0x20 data 7 interleaved → PASS, `ign_cnt_o`=1.
- TIMEOUT=100, len 2; first entry matches at cycle 10, then silence → FAIL with `timeout_o`=1 exactly 100 cycles after the match, `fail_idx_o`=1.
- Armed, one entry matched; assert `rst_i` → all outputs 0 next cycle. Then `exp_we_i` while ARMED after a fresh start → table unchanged, verified by expected pass.
- len 0 start → `pass_o`=1 one cycle later. `clear_i` in PASS → IDLE, `done_o`=0.
